mac_requant: RTL and testbench

//  Output stage directly downstream of the MAC accumulator. Takes a finished
//  32-bit signed accumulation, adds a per-channel bias, applies a rounding

---
 rtl/mac_requant_if.sv | 27 ++
 rtl/mac_requant.sv | 139 +++++++++++++
 tb/tb_mac_requant.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mac_requant_if.sv
// Stream bundle between the MAC accumulator, the requantiser and the
// feature-map write buffer: sample-in side plus result-out side.
interface mac_requant_if #(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
);
  logic signed [ACC_W-1:0]   acc_in;
  logic signed [ACC_W-1:0]   bias;
  logic        [SHIFT_W-1:0] shift;
  logic                      relu_en;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output acc_in, bias, shift, relu_en, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  acc_in, bias, shift, relu_en, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/mac_requant.sv
// Requantisation output stage: bias add, rounding arithmetic right shift,
// optional ReLU and signed saturation, with a saturation event counter.
module mac_requant #(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  mac_requant_if.slave  bus,
  input  logic          sat_clr,
  output logic [15:0]   sat_count
);
  localparam int SUM_W = ACC_W + 1;
  localparam int RND_W = ACC_W + 2;
  localparam logic signed [RND_W-1:0] RND_ONE = {{(RND_W-1){1'b0}}, 1'b1};
  localparam logic [SHIFT_W-1:0]      SH_ONE  = {{(SHIFT_W-1){1'b0}}, 1'b1};

  // Returns {sat, data}; a ReLU clamp to zero is not a saturation.
  function automatic logic [OUT_W:0] clamp_f(input logic signed [RND_W-1:0] v,
                                             input logic relu);
    logic signed [RND_W-1:0] max_v;
    logic signed [RND_W-1:0] min_v;
    max_v = {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    min_v = {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    if (relu && v[RND_W-1]) begin
      clamp_f = {1'b0, {OUT_W{1'b0}}};
    end else if (v > max_v) begin
      clamp_f = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end else if (v < min_v) begin
      clamp_f = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      clamp_f = {1'b0, v[OUT_W-1:0]};
    end
  endfunction

  logic                      adv_s;
  logic signed [SUM_W-1:0]   sum_s;
  logic signed [RND_W-1:0]   ext_s;
  logic signed [RND_W-1:0]   rnd_s;
  logic        [OUT_W:0]     clamp_s;

  logic                      s1_valid_r;
  logic signed [SUM_W-1:0]   s1_sum_r;
  logic        [SHIFT_W-1:0] s1_shift_r;
  logic                      s1_relu_r;
  logic                      s2_valid_r;
  logic signed [RND_W-1:0]   s2_val_r;
  logic                      s2_relu_r;
  logic                      s3_valid_r;
  logic        [OUT_W-1:0]   s3_data_r;
  logic                      s3_sat_r;
  logic                      out_valid_r;
  logic        [OUT_W-1:0]   out_data_r;
  logic        [15:0]        sat_count_r;

  // Whole pipe moves in lock-step; bubbles are kept, nothing is reordered.
  assign adv_s         = ~out_valid_r | bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign sat_count     = sat_count_r;

  // Full-precision bias add, one guard bit so it can never overflow.
  always_comb begin
    sum_s = $signed({bus.acc_in[ACC_W-1], bus.acc_in}) + $signed({bus.bias[ACC_W-1], bus.bias});
  end

  // Round half toward +inf, then arithmetic shift, with one more guard bit.
  always_comb begin
    ext_s = $signed({s1_sum_r[SUM_W-1], s1_sum_r});
    if (s1_shift_r == {SHIFT_W{1'b0}}) begin
      rnd_s = ext_s;
    end else begin
      rnd_s = (ext_s + (RND_ONE <<< (s1_shift_r - SH_ONE))) >>> s1_shift_r;
    end
  end

  // Clamp of the rounded value.
  always_comb begin
    clamp_s = clamp_f(s2_val_r, s2_relu_r);
  end

  // Stage 1: captured sum plus the controls travelling with the sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_sum_r   <= {SUM_W{1'b0}};
      s1_shift_r <= {SHIFT_W{1'b0}};
      s1_relu_r  <= 1'b0;
    end else if (adv_s) begin
      s1_valid_r <= bus.in_valid;
      s1_sum_r   <= sum_s;
      s1_shift_r <= bus.shift;
      s1_relu_r  <= bus.relu_en;
    end
  end

  // Stages 2 and 3: rounded value, then clamped value with its sat flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_val_r   <= {RND_W{1'b0}};
      s2_relu_r  <= 1'b0;
      s3_valid_r <= 1'b0;
      s3_data_r  <= {OUT_W{1'b0}};
      s3_sat_r   <= 1'b0;
    end else if (adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_val_r   <= rnd_s;
      s2_relu_r  <= s1_relu_r;
      s3_valid_r <= s2_valid_r;
      s3_data_r  <= clamp_s[OUT_W-1:0];
      s3_sat_r   <= clamp_s[OUT_W];
    end
  end

  // Output register, held stable while the consumer back-pressures.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
    end else if (adv_s) begin
      out_valid_r <= s3_valid_r;
      out_data_r  <= s3_data_r;
    end
  end

  // Saturation counter: clear wins over a same-cycle event, sticks at max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_count_r <= 16'h0000;
    end else if (sat_clr) begin
      sat_count_r <= 16'h0000;
    end else if (adv_s && s3_valid_r && s3_sat_r && (sat_count_r != 16'hFFFF)) begin
      sat_count_r <= sat_count_r + 16'h0001;
    end
  end
endmodule

// File: tb/tb_mac_requant.sv
// Directed bench for mac_requant: latency, rounding, ReLU, saturation,
// back-pressure, counter clear/limit and asynchronous reset.
module tb_mac_requant;
  logic        clk;
  logic        reset;
  logic        sat_clr;
  logic [15:0] sat_count;
  int          total;
  int          bad;

  mac_requant_if #(.ACC_W(32), .OUT_W(16), .SHIFT_W(5)) bus ();

  mac_requant #(.ACC_W(32), .OUT_W(16), .SHIFT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic rl);
    bus.acc_in  = a;
    bus.bias    = b;
    bus.shift   = sh;
    bus.relu_en = rl;
  endtask

  // Sends one sample into an idle pipe and returns the first result seen.
  task automatic xfer(input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic rl,
                      output logic [15:0] data, output bit ok);
    int n;
    drive(a, b, sh, rl);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      tick();
      n++;
    end
    tick();
    bus.in_valid = 1'b0;
    ok   = 1'b0;
    data = 16'h0000;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (bus.out_valid) begin
        data = bus.out_data;
        ok   = 1'b1;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h want=0000", bus.out_data); end
    total++; if (sat_count !== 16'h0000) begin bad++; $display("FAIL reset_satcnt got=%h want=0000", sat_count); end
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", bus.in_ready); end
  endtask

  task automatic test_latency();
    logic [15:0] d;
    bit          ok;
    drive(32'd1000, 32'd24, 5'd3, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready got=%0b want=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL lat_early_valid edge=+%0d got=%0b want=0", i, bus.out_valid); end
    end
    tick();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid_at_3 got=%0b want=1", bus.out_valid); end
    // (1024+4)>>>3 = 128
    total++; if (bus.out_data !== 16'd128) begin bad++; $display("FAIL lat_data got=%0d want=128", $signed(bus.out_data)); end
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL lat_satcnt got=%0d want=0", sat_count); end
    tick();
    // (1028+4)>>>3 = 129, an exact half rounded up
    xfer(32'd1004, 32'd24, 5'd3, 1'b0, d, ok);
    total++; if (!ok || d !== 16'd129) begin bad++; $display("FAIL lat_half_up ok=%0b got=%0d want=129", ok, $signed(d)); end
  endtask

  task automatic test_round_relu();
    logic [15:0] d;
    bit          ok;
    xfer(32'hFFFF_FFEC, 32'd0, 5'd2, 1'b0, d, ok);
    total++; if (!ok || d !== 16'hFFFB) begin bad++; $display("FAIL rnd_neg20 ok=%0b got=%0d want=-5", ok, $signed(d)); end
    xfer(32'hFFFF_FFEC, 32'd0, 5'd2, 1'b1, d, ok);
    total++; if (!ok || d !== 16'h0000) begin bad++; $display("FAIL relu_neg20 ok=%0b got=%0d want=0", ok, $signed(d)); end
    xfer(32'hFFFF_FFEE, 32'd0, 5'd2, 1'b0, d, ok);
    total++; if (!ok || d !== 16'hFFFC) begin bad++; $display("FAIL rnd_neg18 ok=%0b got=%0d want=-4", ok, $signed(d)); end
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL relu_satcnt got=%0d want=0", sat_count); end
  endtask

  task automatic test_saturation();
    logic [31:0] acc_t [10] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_7FFF, 32'hFFFF_8000, 32'h0000_8000,
                                32'hFFFF_7FFF, 32'hFFFE_7960, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] bias_t[10] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF};
    logic [4:0]  sh_t  [10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd17};
    logic        rl_t  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] exp_t [10] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF,
                                16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF};
    logic [15:0] cnt_t [10] = '{16'd1, 16'd2, 16'd2, 16'd2, 16'd3, 16'd4, 16'd4, 16'd4, 16'd4, 16'd5};
    logic [15:0] d;
    bit          ok;
    for (int i = 0; i < 10; i++) begin
      xfer(acc_t[i], bias_t[i], sh_t[i], rl_t[i], d, ok);
      total++; if (!ok || d !== exp_t[i]) begin bad++; $display("FAIL sat_data[%0d] ok=%0b got=%h want=%h", i, ok, d, exp_t[i]); end
      total++; if (sat_count !== cnt_t[i]) begin bad++; $display("FAIL sat_count[%0d] got=%0d want=%0d", i, sat_count, cnt_t[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int          sent;
    int          got;
    logic [15:0] prev_data;
    bit          prev_stall;
    sent = 0; got = 0; prev_stall = 1'b0; prev_data = 16'h0000;
    drive(32'd0, 32'd0, 5'd0, 1'b0);
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      bus.out_ready = !(cyc >= 5 && cyc < 10);
      if (sent < 6) begin
        bus.in_valid = 1'b1;
        bus.acc_in   = 32'(100 * (sent + 1));
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin bad++; $display("FAIL b2b_hold cyc=%0d valid=%0b got=%0d want=%0d", cyc, bus.out_valid, bus.out_data, prev_data); end
      end
      if (bus.out_valid && !bus.out_ready) begin
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%0b want=0", cyc, bus.in_ready); end
      end
      if (bus.out_valid && bus.out_ready) begin
        total++; if (bus.out_data !== 16'(100 * (got + 1))) begin bad++; $display("FAIL b2b_order idx=%0d got=%0d want=%0d", got, bus.out_data, 100 * (got + 1)); end
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    total++; if (got != 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", got); end
  endtask

  task automatic test_sat_clr();
    total++; if (sat_count !== 16'd5) begin bad++; $display("FAIL clr_pre got=%0d want=5", sat_count); end
    drive(32'h4000_0000, 32'd0, 5'd0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h7FFF) begin bad++; $display("FAIL clr_data valid=%0b got=%h want=7fff", bus.out_valid, bus.out_data); end
    total++; if (sat_count !== 16'd0) begin bad++; $display("FAIL clr_priority got=%0d want=0", sat_count); end
    tick();
  endtask

  task automatic test_sat_limit();
    drive(32'h7FFF_FFFF, 32'd0, 5'd0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    repeat (65536) tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    total++; if (sat_count !== 16'hFFFF) begin bad++; $display("FAIL sat_limit got=%h want=ffff", sat_count); end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    total++; if (sat_count !== 16'h0000) begin bad++; $display("FAIL sat_clr_plain got=%h want=0000", sat_count); end
  endtask

  task automatic test_async_reset();
    int stale;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(32'(1000 * (k + 1)), 32'd0, 5'd0, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    #2;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'd1000) begin bad++; $display("FAIL rst_pre valid=%0b got=%0d want=1000", bus.out_valid, bus.out_data); end
    reset = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_async_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL rst_async_data got=%h want=0000", bus.out_data); end
    #2 reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL rst_stale got=%0d want=0", stale); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b want=1", bus.in_ready); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    sat_clr = 1'b0;
    bus.acc_in = '0; bus.bias = '0; bus.shift = '0; bus.relu_en = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    test_reset();
    test_latency();
    test_round_relu();
    test_saturation();
    test_back_to_back();
    test_sat_clr();
    test_sat_limit();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
